data_bus: RTL and testbench

DATA_BUS -- requirements
Module: data_bus

---
 rtl/data_bus_pkg.sv | 17 +
 rtl/uart_tx.sv | 110 +++++++++++
 rtl/data_bus.sv | 109 ++++++++++
 tb/tb_data_bus.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared constants and types for the data bus slice: address map and the
// UART transmitter state encoding.
package data_bus_pkg;

    localparam logic [31:0] RAM_BASE         = 32'h0000_0000;
    localparam logic [31:0] UART_DATA_ADDR   = 32'h8000_0000;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] CYCLE_ADDR       = 32'h8000_0008;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: pulls bytes from the bus FIFO and shifts them out
// LSB first, chaining frames back to back while the FIFO has data.
module uart_tx
    import data_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_head,
    output logic       pop,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned   BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign tx       = tx_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    baud_d  = '0;
                    shift_d = fifo_head;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so frames have no idle gap
                    if (pop) begin
                        state_d = START;
                        shift_d = fifo_head;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state so it changes on the same edge as the FSM
    always_comb begin
        busy = (state_q != IDLE);
        pop  = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && baud_end));
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_bus.sv
// CPU data-port slave: word RAM, 4-entry UART TX FIFO with status/overflow,
// and a free-running cycle counter, with zero-latency read decode.
module data_bus
    import data_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 256,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic        uart_tx
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [31:0]   ram_mem [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_hit, data_hit, status_hit, cycle_hit;

    logic [7:0]    fifo_mem [4];
    logic [1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [2:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          push_req, push_ok, pop, fifo_empty, fifo_full, busy;

    always_comb begin
        ram_idx    = dataAddr[AW+1:2];
        ram_hit    = ((dataAddr >> (AW + 2)) == (RAM_BASE >> (AW + 2)));
        data_hit   = (dataAddr == UART_DATA_ADDR);
        status_hit = (dataAddr == UART_STATUS_ADDR);
        cycle_hit  = (dataAddr == CYCLE_ADDR);
    end

    always_comb begin
        fifo_empty = (count_q == 3'd0);
        fifo_full  = (count_q == 3'd4);
        push_req   = we && data_hit;
        // A full FIFO still accepts when the transmitter frees a slot on this edge
        push_ok    = push_req && (!fifo_full || pop);
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        wr_ptr_d   = wr_ptr_q + {1'b0, push_ok};
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (we && status_hit && writeData[3]) begin
            ovf_d = 1'b0;
        end
        cycle_d = cycle_q + 32'd1;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cycle_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && ram_hit) begin
            ram_mem[ram_idx] <= writeData;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= writeData[7:0];
        end
    end

    always_comb begin
        readData = '0;
        if (ram_hit) begin
            readData = ram_mem[ram_idx];
        end else if (status_hit) begin
            readData = {28'b0, ovf_q, fifo_empty, fifo_full, busy};
        end else if (cycle_hit) begin
            readData = cycle_q;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk       (clk),
        .n_reset   (n_reset),
        .fifo_empty(fifo_empty),
        .fifo_head (fifo_mem[rd_ptr_q]),
        .pop       (pop),
        .busy      (busy),
        .tx        (uart_tx)
    );

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus: a frame-position model of the bus and UART
// line is checked every cycle, alongside hand-computed literal expectations.
module tb_data_bus;
    import data_bus_pkg::*;

    localparam int unsigned CPB   = 4;
    localparam int unsigned WORDS = 256;
    localparam int unsigned FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [31:0] dataAddr;
    logic [31:0] writeData;
    logic        we;
    logic [31:0] readData;
    logic        uart_tx;

    int errors = 0;
    int checks = 0;

    // Model: frame in flight is (active, position within 10*CPB cycles, byte)
    bit           m_act;
    int unsigned  m_pos;
    logic [7:0]   m_cur;
    logic [7:0]   m_fifo [$];
    bit           m_ovf;
    logic [31:0]  m_edges;
    logic [31:0]  cyc_ofs;
    logic [31:0]  m_ram [int];

    logic         txs [$];
    logic [9:0]   sym;
    logic [7:0]   b;
    int           busy_n;
    logic         lvl;

    data_bus #(
        .RAM_WORDS   (WORDS),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .dataAddr (dataAddr),
        .writeData(writeData),
        .we       (we),
        .readData (readData),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act   = 0;
        m_pos   = 0;
        m_cur   = '0;
        m_fifo.delete();
        m_ovf   = 0;
        m_edges = '0;
    endtask

    task automatic model_step();
        bit last, can_pop;
        last    = m_act && (m_pos == FRAME - 1);
        can_pop = (!m_act || last) && (m_fifo.size() != 0);
        if (can_pop) begin
            m_cur = m_fifo.pop_front();
            m_act = 1;
            m_pos = 0;
        end else if (last) begin
            m_act = 0;
        end else if (m_act) begin
            m_pos++;
        end
        if (we && dataAddr == UART_DATA_ADDR) begin
            if (m_fifo.size() < 4) m_fifo.push_back(writeData[7:0]);
            else m_ovf = 1;
        end else if (we && dataAddr == UART_STATUS_ADDR && writeData[3]) begin
            m_ovf = 0;
        end
        if (we && dataAddr < 32'(4 * WORDS)) m_ram[int'(dataAddr >> 2)] = writeData;
        m_edges++;
    endtask

    function automatic logic exp_tx();
        if (!m_act) return 1'b1;
        if (m_pos < CPB) return 1'b0;
        if (m_pos < 9 * CPB) return m_cur[(m_pos - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic compare_cycle();
        logic [31:0] e;
        check("tx_line", {31'b0, uart_tx}, {31'b0, exp_tx()});
        if (dataAddr < 32'(4 * WORDS)) begin
            if (m_ram.exists(int'(dataAddr >> 2)))
                check("ram_read", readData, m_ram[int'(dataAddr >> 2)]);
        end else begin
            if (dataAddr == UART_STATUS_ADDR)
                e = {28'b0, m_ovf, m_fifo.size() == 0, m_fifo.size() == 4, m_act};
            else if (dataAddr == CYCLE_ADDR)
                e = m_edges + cyc_ofs;
            else
                e = '0;
            check("bus_read", readData, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (n_reset) model_step();
        else model_reset();
        @(negedge clk);
        compare_cycle();
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        we        = w;
        dataAddr  = a;
        writeData = d;
    endtask

    initial begin
        n_reset = 1'b0;
        cyc_ofs = '0;
        drive(0, UART_STATUS_ADDR, 0);
        model_reset();
        tick();
        tick();
        check("rst_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_status", readData, 32'h4);

        n_reset = 1'b1;
        drive(0, CYCLE_ADDR, 0);
        repeat (10) tick();
        check("cycle_10", readData, 32'd10);

        drive(1, 32'h0, 32'h0000_01FE);
        tick();
        drive(0, 32'h0, 0);
        #1 check("ram_load0", readData, 32'h0000_01FE);
        drive(1, 32'h3FC, 32'hDEAD_BEEF);
        tick();
        drive(0, 32'h3FF, 0);
        #1 check("ram_top_unaligned", readData, 32'hDEAD_BEEF);
        drive(1, 32'h400, 32'hCAFE_F00D);
        tick();
        drive(0, 32'h400, 0);
        #1 check("unmapped_read", readData, 32'h0);
        drive(0, 32'h0, 0);
        #1 check("no_alias", readData, 32'h0000_01FE);
        drive(1, CYCLE_ADDR, 32'h1234_5678);
        tick();
        drive(1, 32'h8000_000C, 32'h1234);
        tick();
        drive(0, 32'h8000_000C, 0);
        #1 check("unmapped_hi", readData, 32'h0);

        drive(1, UART_DATA_ADDR, 32'h0000_0155);
        tick();
        drive(0, UART_STATUS_ADDR, 0);
        sym    = 10'b1010101010;
        busy_n = 0;
        #1 check("tx_before_pop", {31'b0, uart_tx}, 32'd1);
        for (int k = 1; k <= int'(FRAME) + 1; k++) begin
            tick();
            lvl = (k > int'(FRAME)) ? 1'b1 : sym[(k - 1) / int'(CPB)];
            check("tx_0x55", {31'b0, uart_tx}, {31'b0, lvl});
            busy_n += int'(readData[0]);
        end
        check("busy_cycles", busy_n, 32'd40);

        txs.delete();
        for (int i = 1; i <= 6; i++) begin
            drive(1, UART_DATA_ADDR, 32'(i));
            tick();
            txs.push_back(uart_tx);
        end
        drive(0, UART_STATUS_ADDR, 0);
        #1 check("ovf_full_status", readData, 32'hB);
        repeat (200) begin
            tick();
            txs.push_back(uart_tx);
        end
        for (int i = 0; i < 5; i++) begin
            check("frame_start", {31'b0, txs[1 + 40 * i]}, 32'd0);
            for (int j = 0; j < 8; j++) b[j] = txs[1 + 40 * i + 4 + 4 * j + 1];
            check("frame_byte", {24'b0, b}, 32'(i + 1));
            check("frame_stop", {31'b0, txs[1 + 40 * i + 37]}, 32'd1);
        end
        check("idle_after", {31'b0, txs[201]}, 32'd1);
        check("idle_late", {31'b0, txs[205]}, 32'd1);
        #1 check("status_drained", readData, 32'hC);

        drive(1, UART_STATUS_ADDR, 32'h7);
        tick();
        drive(0, UART_STATUS_ADDR, 0);
        #1 check("ovf_kept", readData, 32'hC);
        drive(1, UART_STATUS_ADDR, 32'h8);
        tick();
        drive(0, UART_STATUS_ADDR, 0);
        #1 check("ovf_cleared", readData, 32'h4);

        drive(1, UART_DATA_ADDR, 32'h00);
        tick();
        drive(1, UART_DATA_ADDR, 32'h3C);
        tick();
        drive(0, UART_STATUS_ADDR, 0);
        repeat (6) tick();
        #1 check("tx_mid_data", {31'b0, uart_tx}, 32'd0);
        check("status_mid_data", readData, 32'h1);
        #1 n_reset = 1'b0;
        model_reset();
        #1 check("rst_async_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_async_status", readData, 32'h4);
        tick();
        tick();
        n_reset = 1'b1;
        repeat (60) tick();
        check("no_resend_tx", {31'b0, uart_tx}, 32'd1);
        check("no_resend_status", readData, 32'h4);

        drive(0, CYCLE_ADDR, 0);
        force dut.cycle_q = 32'hFFFF_FFFF;
        cyc_ofs = 32'hFFFF_FFFF - m_edges;
        #1 release dut.cycle_q;
        #1 check("cycle_max", readData, 32'hFFFF_FFFF);
        tick();
        check("cycle_wrap", readData, 32'h0);
        tick();
        check("cycle_after_wrap", readData, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
